// File: rtl/frame_streamer.sv
// frame_streamer: reads one frame from a circular BRAM, converts it to
// two's complement, optionally windows it and streams it with backpressure.
module frame_streamer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int FRAME_LEN = 4096,
    parameter int COEFF_W   = 24,
    parameter int WINDOW_EN = 1,
    localparam int CIDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   head,
    output logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic [CIDX_W-1:0]   coeff_idx,
    input  logic [COEFF_W-1:0]  coeff,
    input  logic                last_missing,
    output logic [2*DATA_W-1:0] frame_tdata,
    output logic                frame_tvalid,
    output logic                frame_tlast,
    input  logic                frame_tready,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          abort_count,
    output logic [7:0]          overrun_count
);
    localparam int KW    = $clog2(FRAME_LEN + 1);
    localparam int DEPTH = 4;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [KW-1:0]     k_q, k_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] buf_d [DEPTH];
    logic              blast_q [DEPTH];
    logic              blast_d [DEPTH];
    logic [1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [7:0]        abort_q, abort_d;
    logic [7:0]        ovr_q, ovr_d;

    logic              streaming, rd_en, pop, final_hs;
    logic [DATA_W-1:0] s_val, re_val;

    assign streaming = (state_q == STREAM);
    // A read is issued only if its beat is guaranteed a skid slot.
    assign rd_en = streaming && !last_missing
                 && (k_q < KW'(FRAME_LEN))
                 && (({1'b0, cnt_q} + 4'(infl_q)) < 4'(DEPTH));
    assign pop      = (cnt_q != 3'd0) && frame_tready;
    assign final_hs = pop && blast_q[rd_q];
    assign addr     = base_q + ADDR_W'(k_q);
    assign s_val    = {~data[DATA_W-1], data[DATA_W-2:0]};

    if (WINDOW_EN != 0) begin : g_win
        localparam int PW = COEFF_W + DATA_W + 1;
        logic signed [PW-1:0] prod;
        logic unused_prod;
        assign prod = PW'($signed({1'b0, coeff})) * PW'($signed(s_val));
        assign re_val = prod[COEFF_W +: DATA_W];
        assign unused_prod = ^{prod[PW-1], prod[COEFF_W-1:0]};
        assign coeff_idx = CIDX_W'(k_q);
    end else begin : g_bypass
        logic unused_coeff;
        assign re_val = s_val;
        assign unused_coeff = ^coeff;
        assign coeff_idx = '0;
    end

    // Next state: sequencing, skid buffer and status counters.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        buf_d       = buf_q;
        blast_d     = blast_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        abort_d     = abort_q;
        ovr_d       = ovr_q;
        if (streaming && start && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end
        if (streaming && last_missing) begin
            state_d = IDLE;
            wr_d    = 2'd0;
            rd_d    = 2'd0;
            cnt_d   = 3'd0;
            if (abort_q != 8'hFF) begin
                abort_d = abort_q + 8'd1;
            end
        end else begin
            if (rd_en) begin
                k_d         = k_q + KW'(1);
                infl_d      = 1'b1;
                infl_last_d = (k_q == KW'(FRAME_LEN - 1));
            end
            if (infl_q) begin
                buf_d[wr_q]   = re_val;
                blast_d[wr_q] = infl_last_q;
                wr_d          = wr_q + 2'd1;
            end
            if (pop) begin
                rd_d = rd_q + 2'd1;
            end
            cnt_d = cnt_q + {2'b0, infl_q} - {2'b0, pop};
            if (!streaming && start) begin
                state_d = STREAM;
                base_d  = head;
                k_d     = '0;
            end
            if (final_hs) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            k_q         <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i]   <= '0;
                blast_q[i] <= 1'b0;
            end
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            abort_q <= 8'd0;
            ovr_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            k_q         <= k_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            buf_q       <= buf_d;
            blast_q     <= blast_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            ovr_q       <= ovr_d;
        end
    end

    assign frame_tvalid  = (cnt_q != 3'd0);
    assign frame_tlast   = frame_tvalid && blast_q[rd_q];
    assign frame_tdata   = {{DATA_W{1'b0}}, buf_q[rd_q]};
    assign busy          = streaming;
    assign frame_done    = done_q;
    assign abort_count   = abort_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: table vectors plus a frame-level reference model
// for two frame_streamer configurations.
module tb_frame_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tready;
    logic        st [2];
    logic        lm [2];
    logic [11:0] head0, addr0, cidx0;
    logic [9:0]  head1, addr1, cidx1;
    logic [15:0] data0, data1;
    logic [23:0] coeff0, coeff1;
    logic [31:0] td [2];
    logic        tv [2];
    logic        tl [2];
    logic        bsy [2];
    logic        dn [2];
    logic [7:0]  abc [2];
    logic [7:0]  ovc [2];

    logic [15:0] bram0 [4096];
    logic [15:0] bram1 [1024];
    logic [23:0] rom1 [1024];

    always @(posedge clk) begin
        data0  <= bram0[addr0];
        data1  <= bram1[addr1];
        coeff1 <= rom1[cidx1];
    end

    frame_streamer #(.DATA_W(16), .ADDR_W(12), .FRAME_LEN(4096),
                     .COEFF_W(24), .WINDOW_EN(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .start(st[0]), .head(head0),
        .addr(addr0), .data(data0), .coeff_idx(cidx0), .coeff(coeff0),
        .last_missing(lm[0]), .frame_tdata(td[0]), .frame_tvalid(tv[0]),
        .frame_tlast(tl[0]), .frame_tready(tready), .busy(bsy[0]),
        .frame_done(dn[0]), .abort_count(abc[0]), .overrun_count(ovc[0]));

    frame_streamer #(.DATA_W(16), .ADDR_W(10), .FRAME_LEN(1000),
                     .COEFF_W(24), .WINDOW_EN(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .start(st[1]), .head(head1),
        .addr(addr1), .data(data1), .coeff_idx(cidx1), .coeff(coeff1),
        .last_missing(lm[1]), .frame_tdata(td[1]), .frame_tvalid(tv[1]),
        .frame_tlast(tl[1]), .frame_tready(tready), .busy(bsy[1]),
        .frame_done(dn[1]), .abort_count(abc[1]), .overrun_count(ovc[1]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   b [2];
    bit   active [2];
    bit   exp_dn [2];
    bit   stl [2];
    logic [31:0] pd [2];
    logic pl [2];
    int   ndone [2];
    int   h [2];
    logic [15:0] cap1 [1000];

    function automatic int flen(input int id);
        return (id == 0) ? 4096 : 1000;
    endfunction

    function automatic logic [31:0] exp_beat(input int id, input int k);
        int a;
        int s;
        longint p;
        if (id == 0) begin
            a = (h[0] + k) % 4096;
            s = int'(bram0[a]) - 32768;
        end else begin
            a = (h[1] + k) % 1024;
            s = int'(bram1[a]) - 32768;
            p = longint'(rom1[k]) * longint'(s);
            s = int'(p >>> 24);
        end
        return {16'h0, s[15:0]};
    endfunction

    // Output monitor: handshakes, stability while stalled, done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                stl[i]    = 1'b0;
                exp_dn[i] = 1'b0;
            end else begin
                chk("frame_done", dn[i], exp_dn[i]);
                if (exp_dn[i]) chk("busy_fall", bsy[i], 0);
                exp_dn[i] = 1'b0;
                if (dn[i]) ndone[i]++;
                if (stl[i]) begin
                    chk("hold_valid", tv[i], 1);
                    chk("hold_data", td[i], pd[i]);
                    chk("hold_last", tl[i], pl[i]);
                end
                stl[i] = tv[i] && !tready && !lm[i];
                pd[i]  = td[i];
                pl[i]  = tl[i];
                if (tv[i] && tready && !lm[i]) begin
                    if (!active[i]) begin
                        chk("spurious_beat", tv[i], 0);
                    end else begin
                        chk("beat_data", td[i], exp_beat(i, b[i]));
                        chk("beat_last", tl[i], b[i] == flen(i) - 1);
                        if (i == 1) cap1[b[i]] = td[i][15:0];
                        if (b[i] == flen(i) - 1) begin
                            active[i] = 1'b0;
                            exp_dn[i] = 1'b1;
                        end
                        b[i]++;
                    end
                end
            end
        end
    end

    int mode = 0;
    int stretch = 0;
    initial begin
        int r;
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                tready = 1'b1;
            end else if (stretch > 0) begin
                tready = 1'b0;
                stretch--;
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    stretch = 4;
                    tready  = 1'b0;
                end else begin
                    tready = (r > 3);
                end
            end
        end
    end

    task automatic launch(input int id, input int hd);
        int lat;
        if (id == 0) head0 = 12'(hd);
        else head1 = 10'(hd);
        h[id] = hd;
        b[id] = 0;
        active[id] = 1'b1;
        chk("busy_idle", bsy[id], 0);
        st[id] = 1'b1;
        tick();
        st[id] = 1'b0;
        chk("busy_rise", bsy[id], 1);
        lat = 1;
        while (!tv[id] && lat < 8) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", lat, 3);
        if (id == 0) chk("coeff_idx_hold", cidx0, 0);
    endtask

    task automatic wait_beats(input int id, input int n);
        int t = 0;
        while (b[id] < n && t < 20000) begin
            tick();
            t++;
        end
        if (t >= 20000) chk("wait_beats_timeout", b[id], n);
    endtask

    task automatic wait_done(input int id);
        int t = 0;
        int n0 = ndone[id];
        while (ndone[id] == n0 && t < 20000) begin
            tick();
            t++;
        end
        if (t >= 20000) chk("wait_done_timeout", ndone[id], n0 + 1);
    endtask

    task automatic chk_idle(input int id);
        chk("rst_tdata", td[id], 0);
        chk("rst_tvalid", tv[id], 0);
        chk("rst_tlast", tl[id], 0);
        chk("rst_busy", bsy[id], 0);
        chk("rst_done", dn[id], 0);
        chk("rst_abort", abc[id], 0);
        chk("rst_overrun", ovc[id], 0);
    endtask

    task automatic pulse_start(input int id);
        st[id] = 1'b1;
        tick();
        st[id] = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [15:0] data;
        logic [23:0] coeff;
        logic [15:0] want;
    } vec_t;

    vec_t tab [9];

    initial begin
        int nd;
        tab[0] = '{"win_half_pos", 16'hC000, 24'h800000, 16'h2000};
        tab[1] = '{"win_half_neg", 16'h0000, 24'h800000, 16'hC000};
        tab[2] = '{"win_zero_s",   16'h8000, 24'hFFFFFF, 16'h0000};
        tab[3] = '{"win_max_pos",  16'hFFFF, 24'hFFFFFF, 16'h7FFE};
        tab[4] = '{"win_max_neg",  16'h0001, 24'hFFFFFF, 16'h8001};
        tab[5] = '{"win_quarter",  16'h4000, 24'h400000, 16'hF000};
        tab[6] = '{"win_zero_c",   16'hFFFF, 24'h000000, 16'h0000};
        tab[7] = '{"win_floor_n",  16'h7FFF, 24'h000001, 16'hFFFF};
        tab[8] = '{"win_floor_p",  16'h8001, 24'h000001, 16'h0000};

        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        lm[0] = 1'b0; lm[1] = 1'b0;
        head0 = '0; head1 = '0; coeff0 = '0;
        for (int i = 0; i < 2; i++) begin
            b[i] = 0; active[i] = 1'b0; exp_dn[i] = 1'b0;
            stl[i] = 1'b0; ndone[i] = 0; h[i] = 0;
        end
        for (int i = 0; i < 4096; i++) bram0[i] = 16'(i);
        for (int i = 0; i < 1024; i++) begin
            bram1[i] = 16'($urandom);
            rom1[i]  = 24'($urandom);
        end

        repeat (3) tick();
        chk_idle(0);
        chk_idle(1);
        chk("rst_addr0", addr0, 0);
        chk("rst_addr1", addr1, 0);
        chk("rst_cidx1", cidx1, 0);
        rst_n = 1'b1;
        tick();

        launch(0, 'hF00);
        wait_done(0);
        chk("beats_clean", b[0], 4096);

        mode = 1;
        launch(0, $urandom_range(0, 4095));
        wait_done(0);
        chk("beats_stalled", b[0], 4096);
        mode = 0;
        repeat (10) tick();

        launch(0, $urandom_range(0, 4095));
        wait_beats(0, 10);
        pulse_start(0);
        wait_beats(0, 100);
        pulse_start(0);
        chk("overrun_two", ovc[0], 2);
        wait_beats(0, 4095);
        pulse_start(0);
        wait_done(0);
        chk("beats_overrun", b[0], 4096);
        chk("overrun_final_hs", ovc[0], 3);
        tick();
        chk("no_restart", bsy[0], 0);

        launch(0, $urandom_range(0, 4095));
        wait_beats(0, 500);
        nd = ndone[0];
        lm[0] = 1'b1;
        active[0] = 1'b0;
        tick();
        lm[0] = 1'b0;
        chk("abort_tvalid", tv[0], 0);
        chk("abort_busy", bsy[0], 0);
        chk("abort_count", abc[0], 1);
        repeat (5) tick();
        chk("abort_no_done", ndone[0], nd);
        launch(0, 'h123);
        wait_done(0);
        chk("beats_after_abort", b[0], 4096);

        launch(0, $urandom_range(0, 4095));
        wait_beats(0, 2000);
        rst_n = 1'b0;
        active[0] = 1'b0;
        #1;
        chk_idle(0);
        chk("rst_mid_addr", addr0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(0, 'h7FF);
        wait_done(0);
        chk("beats_after_reset", b[0], 4096);
        chk("abort_cleared", abc[0], 0);

        for (int i = 0; i < 9; i++) begin
            bram1[(900 + i) % 1024] = tab[i].data;
            rom1[i] = tab[i].coeff;
        end
        launch(1, 900);
        wait_done(1);
        chk("beats_len1000", b[1], 1000);
        for (int i = 0; i < 9; i++) chk(tab[i].nm, cap1[i], tab[i].want);

        mode = 1;
        launch(1, $urandom_range(0, 1023));
        wait_done(1);
        chk("beats_len1000_stall", b[1], 1000);
        mode = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
